// File: rtl/rf_writeback_if.sv
// Write-back bus: three result producers, decode issue/query, and the register-file write port.
interface rf_writeback_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned RD_W = 5;

  logic            alu_valid;
  logic [RD_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [RD_W-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            mdu_valid;
  logic [RD_W-1:0] mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;

  logic            issue_valid;
  logic [RD_W-1:0] issue_rd;
  logic [RD_W-1:0] query_rs1;
  logic [RD_W-1:0] query_rs2;
  logic            busy_rs1;
  logic            busy_rs2;

  logic            write_enable;
  logic [RD_W-1:0] write_addr;
  logic [XLEN-1:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output issue_valid, issue_rd, query_rs1, query_rs2,
    input  alu_ready, lsu_ready, mdu_ready,
    input  busy_rs1, busy_rs2,
    input  write_enable, write_addr, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  issue_valid, issue_rd, query_rs1, query_rs2,
    output alu_ready, lsu_ready, mdu_ready,
    output busy_rs1, busy_rs2,
    output write_enable, write_addr, write_data
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Arbitrates ALU/LSU/MDU results onto the register-file write port and tracks
// pending destinations so decode can stall on RAW hazards.
module rf_writeback_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          async_reset,
  rf_writeback_if.slave bus
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned NREG  = 32;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU,
    SRC_MDU
  } src_e;

  src_e            grant_c;
  logic            lsu_starved_c;
  logic            mdu_starved_c;
  logic [RD_W-1:0] grant_rd_c;
  logic [XLEN-1:0] grant_data_c;

  logic [CNT_W-1:0] lsu_cnt, lsu_cnt_nxt;
  logic [CNT_W-1:0] mdu_cnt, mdu_cnt_nxt;
  logic [NREG-1:0]  pending, pending_nxt;
  logic             we_q, we_nxt;
  logic [RD_W-1:0]  addr_q, addr_nxt;
  logic [XLEN-1:0]  data_q, data_nxt;

  // Starved sources first (LSU before MDU), then fixed ALU > LSU > MDU; nothing is granted in reset.
  always_comb begin
    grant_c       = SRC_NONE;
    lsu_starved_c = bus.lsu_valid && (lsu_cnt >= LIMIT);
    mdu_starved_c = bus.mdu_valid && (mdu_cnt >= LIMIT);
    if (!async_reset)        grant_c = SRC_NONE;
    else if (lsu_starved_c)  grant_c = SRC_LSU;
    else if (mdu_starved_c)  grant_c = SRC_MDU;
    else if (bus.alu_valid)  grant_c = SRC_ALU;
    else if (bus.lsu_valid)  grant_c = SRC_LSU;
    else if (bus.mdu_valid)  grant_c = SRC_MDU;
  end

  always_comb begin
    grant_rd_c   = '0;
    grant_data_c = '0;
    case (grant_c)
      SRC_ALU: begin grant_rd_c = bus.alu_rd; grant_data_c = bus.alu_data; end
      SRC_LSU: begin grant_rd_c = bus.lsu_rd; grant_data_c = bus.lsu_data; end
      SRC_MDU: begin grant_rd_c = bus.mdu_rd; grant_data_c = bus.mdu_data; end
      default: begin grant_rd_c = '0;         grant_data_c = '0;          end
    endcase
  end

  assign bus.alu_ready = (grant_c == SRC_ALU);
  assign bus.lsu_ready = (grant_c == SRC_LSU);
  assign bus.mdu_ready = (grant_c == SRC_MDU);

  // Next state: saturating starvation counters, scoreboard (issue beats retire), write register.
  always_comb begin
    lsu_cnt_nxt = lsu_cnt;
    mdu_cnt_nxt = mdu_cnt;
    pending_nxt = pending;
    we_nxt      = 1'b0;
    addr_nxt    = addr_q;
    data_nxt    = data_q;

    if (!bus.lsu_valid || grant_c == SRC_LSU) lsu_cnt_nxt = '0;
    else if (lsu_cnt < LIMIT)                 lsu_cnt_nxt = lsu_cnt + CNT_W'(1);

    if (!bus.mdu_valid || grant_c == SRC_MDU) mdu_cnt_nxt = '0;
    else if (mdu_cnt < LIMIT)                 mdu_cnt_nxt = mdu_cnt + CNT_W'(1);

    if (grant_c != SRC_NONE && grant_rd_c != '0) begin
      pending_nxt[grant_rd_c] = 1'b0;
      we_nxt                  = 1'b1;
      addr_nxt                = grant_rd_c;
      data_nxt                = grant_data_c;
    end
    if (bus.issue_valid) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      lsu_cnt <= '0;
      mdu_cnt <= '0;
      pending <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      lsu_cnt <= lsu_cnt_nxt;
      mdu_cnt <= mdu_cnt_nxt;
      pending <= pending_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
    end
  end

  assign bus.write_enable = we_q;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;

  // The in-flight write still counts as busy until the register file captures it at negedge.
  assign bus.busy_rs1 = (bus.query_rs1 != '0) &&
                        (pending[bus.query_rs1] || (we_q && addr_q == bus.query_rs1));
  assign bus.busy_rs2 = (bus.query_rs2 != '0) &&
                        (pending[bus.query_rs2] || (we_q && addr_q == bus.query_rs2));
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_rf_writeback_arbiter;
  localparam int unsigned LIMIT = 4;

  logic clock;
  logic async_reset;
  int   checks;
  int   errors;

  rf_writeback_if #(.XLEN(32)) bus ();

  rf_writeback_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .clock      (clock),
    .async_reset(async_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_lsu_wait = 0;
  int          m_mdu_wait = 0;
  bit          m_pend[32];
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          lsu_streak = 0;
  int          mdu_streak = 0;

  task automatic m_reset();
    m_lsu_wait = 0;
    m_mdu_wait = 0;
    for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
    lsu_streak = 0; mdu_streak = 0;
  endtask

  // 0=ALU 1=LSU 2=MDU -1=none
  function automatic int m_winner();
    if (bus.lsu_valid && m_lsu_wait >= int'(LIMIT)) return 1;
    if (bus.mdu_valid && m_mdu_wait >= int'(LIMIT)) return 2;
    if (bus.alu_valid) return 0;
    if (bus.lsu_valid) return 1;
    if (bus.mdu_valid) return 2;
    return -1;
  endfunction

  function automatic logic m_busy(input logic [4:0] q);
    return (q != 5'd0) && (m_pend[q] || (m_we && m_addr == q));
  endfunction

  task automatic m_step(input int w);
    logic [4:0]  rd;
    logic [31:0] d;
    rd = '0; d = '0;
    if (w == 0)      begin rd = bus.alu_rd; d = bus.alu_data; end
    else if (w == 1) begin rd = bus.lsu_rd; d = bus.lsu_data; end
    else if (w == 2) begin rd = bus.mdu_rd; d = bus.mdu_data; end
    m_we = (w >= 0) && (rd != 5'd0);
    if (m_we) begin
      m_pend[rd] = 1'b0;
      m_addr = rd;
      m_data = d;
    end
    if (bus.issue_valid && bus.issue_rd != 5'd0) m_pend[bus.issue_rd] = 1'b1;
    m_lsu_wait = (bus.lsu_valid && w != 1) ? m_lsu_wait + 1 : 0;
    m_mdu_wait = (bus.mdu_valid && w != 2) ? m_mdu_wait + 1 : 0;
  endtask

  // Compare process: inputs change at negedge, checked 2 time units later, model advances.
  always @(negedge clock) begin
    int         w;
    logic [2:0] exp_rdy;
    #2;
    if (!async_reset) begin
      m_reset();
      chk("reset_write_enable", 32'(bus.write_enable), 32'(0));
      chk("reset_write_addr",   32'(bus.write_addr),   32'(0));
      chk("reset_write_data",   bus.write_data,        32'(0));
      chk("reset_busy",         32'({bus.busy_rs2, bus.busy_rs1}), 32'(0));
    end else begin
      w = m_winner();
      exp_rdy = (w == 0) ? 3'b001 : (w == 1) ? 3'b010 : (w == 2) ? 3'b100 : 3'b000;
      chk("ready_vec", 32'({bus.mdu_ready, bus.lsu_ready, bus.alu_ready}), 32'(exp_rdy));
      chk("busy_rs1", 32'(bus.busy_rs1), 32'(m_busy(bus.query_rs1)));
      chk("busy_rs2", 32'(bus.busy_rs2), 32'(m_busy(bus.query_rs2)));
      chk("write_enable", 32'(bus.write_enable), 32'(m_we));
      if (m_we) begin
        chk("write_addr", 32'(bus.write_addr), 32'(m_addr));
        chk("write_data", bus.write_data, m_data);
      end
      lsu_streak = (bus.lsu_valid && !bus.lsu_ready) ? lsu_streak + 1 : 0;
      mdu_streak = (bus.mdu_valid && !bus.mdu_ready) ? mdu_streak + 1 : 0;
      if (bus.lsu_valid) chk("lsu_starve_bound", 32'(lsu_streak <= int'(LIMIT) + 1), 32'(1));
      if (bus.mdu_valid) chk("mdu_starve_bound", 32'(mdu_streak <= int'(LIMIT) + 1), 32'(1));
      m_step(w);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.query_rs1 = '0; bus.query_rs2 = '0;
  endtask

  logic [2:0] exp_pat [12];

  initial begin
    checks = 0;
    errors = 0;
    exp_pat = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100,
                3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
    async_reset = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    #3;
    chk("lit_reset_we",   32'(bus.write_enable), 32'(0));
    chk("lit_reset_data", bus.write_data,        32'(0));
    @(negedge clock);
    #1 async_reset = 1'b1;

    // ALU only: accepted same cycle, write visible for exactly one cycle
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #3 chk("lit_alu_ready", 32'(bus.alu_ready), 32'(1));
    @(negedge clock);
    bus.alu_valid = 1'b0;
    #3;
    chk("lit_alu_we",   32'(bus.write_enable), 32'(1));
    chk("lit_alu_addr", 32'(bus.write_addr),   32'(5));
    chk("lit_alu_data", bus.write_data,        32'hDEADBEEF);
    @(negedge clock);
    #3 chk("lit_alu_we_drop", 32'(bus.write_enable), 32'(0));

    // All three valid continuously
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111_1111;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2222_2222;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h3333_3333;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      #3 chk($sformatf("lit_contend_cycle%0d", i + 1),
             32'({bus.mdu_ready, bus.lsu_ready, bus.alu_ready}), 32'(exp_pat[i]));
    end

    // Scoreboard: issue rd7, retire through LSU
    @(negedge clock);
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.query_rs1 = 5'd7;
    #3 chk("lit_issue_same_cycle_busy", 32'(bus.busy_rs1), 32'(0));
    @(negedge clock);
    bus.issue_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0777;
    #3;
    chk("lit_busy7_pending", 32'(bus.busy_rs1),  32'(1));
    chk("lit_lsu_ready7",    32'(bus.lsu_ready), 32'(1));
    @(negedge clock);
    bus.lsu_valid = 1'b0;
    #3;
    chk("lit_busy7_during_write", 32'(bus.busy_rs1),   32'(1));
    chk("lit_write_addr7",        32'(bus.write_addr), 32'(7));
    @(negedge clock);
    #3;
    chk("lit_busy7_after_write", 32'(bus.busy_rs1), 32'(0));
    chk("lit_busy_rs2_zero",     32'(bus.busy_rs2), 32'(0));

    // Same-cycle issue and retire of rd9: issue wins
    @(negedge clock);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.query_rs1 = 5'd9;
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0099;
    #3 chk("lit_alu_ready9", 32'(bus.alu_ready), 32'(1));
    @(negedge clock);
    bus.issue_valid = 1'b0; bus.alu_valid = 1'b0;
    @(negedge clock);
    #3;
    chk("lit_set_wins_busy9", 32'(bus.busy_rs1),     32'(1));
    chk("lit_set_wins_we",    32'(bus.write_enable), 32'(0));
    @(negedge clock);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_0999;
    #3 chk("lit_mdu_ready9", 32'(bus.mdu_ready), 32'(1));
    @(negedge clock);
    bus.mdu_valid = 1'b0;
    @(negedge clock);
    #3 chk("lit_busy9_cleared", 32'(bus.busy_rs1), 32'(0));

    // rd=0 result: accepted, no write
    @(negedge clock);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h0000_1234;
    #3 chk("lit_mdu_ready_rd0", 32'(bus.mdu_ready), 32'(1));
    @(negedge clock);
    bus.mdu_valid = 1'b0;
    #3 chk("lit_rd0_no_write", 32'(bus.write_enable), 32'(0));

    // Reset mid-stream: LSU counter saturated, pending 3 and 4, write in flight
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h0000_A0A0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'h0000_B0B0;
    bus.query_rs1 = 5'd3; bus.query_rs2 = 5'd4;
    @(negedge clock);
    @(negedge clock);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    @(negedge clock);
    bus.issue_rd = 5'd4;
    @(posedge clock);
    #1;
    chk("lit_pre_reset_we",    32'(bus.write_enable), 32'(1));
    chk("lit_pre_reset_busy",  32'({bus.busy_rs2, bus.busy_rs1}), 32'(3));
    #1 async_reset = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    chk("lit_reset_now_we",   32'(bus.write_enable), 32'(0));
    chk("lit_reset_now_busy", 32'({bus.busy_rs2, bus.busy_rs1}), 32'(0));
    @(negedge clock);
    @(negedge clock);
    #1 async_reset = 1'b1;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'h0000_C0C0;
    #2;
    chk("lit_after_reset_alu_wins", 32'({bus.mdu_ready, bus.lsu_ready, bus.alu_ready}), 32'(1));
    chk("lit_after_reset_busy",     32'({bus.busy_rs2, bus.busy_rs1}), 32'(0));
    repeat (7) @(negedge clock);
    idle();
    repeat (3) @(negedge clock);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
